// File: rtl/axi_lite_rr_master.sv
// Round-robin arbiter that funnels single-word read/write commands from
// NUM_REQ local requesters into one AXI-Lite master port.
module axi_lite_rr_master #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      busy,
  output logic [ADDR_W-1:0]         AWADDR,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [DATA_W-1:0]         WDATA,
  output logic                      WVALID,
  input  logic                      WREADY,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY,
  output logic [ADDR_W-1:0]         ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  input  logic [DATA_W-1:0]         RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RVALID,
  output logic                      RREADY
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [IW-1:0]       r_rr_ptr;
  logic [IW-1:0]       r_gnt;
  logic                r_aw_done;
  logic                r_w_done;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_arvalid;
  logic                r_rready;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [ADDR_W-1:0]   r_araddr;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [1:0]          r_rsp_resp;
  logic                r_busy;

  logic                w_found;
  logic [IW-1:0]       w_win;
  logic [IW-1:0]       w_idx;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_aw_fin;
  logic                w_w_fin;

  // Search begins just after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IW'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign req_ready = (!ARESET && r_state == S_IDLE && w_found)
                   ? (ONE << w_win) : '0;

  assign w_aw_hs  = r_awvalid & AWREADY;
  assign w_w_hs   = r_wvalid & WREADY;
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done | w_w_hs;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= IW'(NUM_REQ - 1);
      r_gnt       <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_araddr    <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt    <= w_win;
            r_rr_ptr <= w_win;
            r_busy   <= 1'b1;
            if (req_write[w_win]) begin
              r_awaddr  <= req_addr[int'(w_win)*ADDR_W +: ADDR_W];
              r_wdata   <= req_wdata[int'(w_win)*DATA_W +: DATA_W];
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_ADDR;
            end else begin
              r_araddr  <= req_addr[int'(w_win)*ADDR_W +: ADDR_W];
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end
          end
        end
        S_WR_ADDR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          // Later assignments win: both flags clear once AW and W are done.
          if (w_aw_fin && w_w_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (BVALID && r_bready) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= BRESP;
            r_rsp_valid <= ONE << r_gnt;
            r_state     <= S_RESP;
          end
        end
        S_RD_ADDR: begin
          if (r_arvalid && ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (RVALID && r_rready) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= RDATA;
            r_rsp_resp  <= RRESP;
            r_rsp_valid <= ONE << r_gnt;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_rsp_valid <= '0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;
  assign busy      = r_busy;
  assign AWADDR    = r_awaddr;
  assign AWVALID   = r_awvalid;
  assign WDATA     = r_wdata;
  assign WVALID    = r_wvalid;
  assign BREADY    = r_bready;
  assign ARADDR    = r_araddr;
  assign ARVALID   = r_arvalid;
  assign RREADY    = r_rready;

endmodule

// File: tb/tb_axi_lite_rr_master.sv
// Bench for axi_lite_rr_master: directed vector table against a small
// AXI-Lite register slave with programmable ready/valid delays.
module tb_axi_lite_rr_master;

  logic        ACLK;
  logic        ARESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic [3:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  axi_lite_rr_master dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Slave model: four word registers, delays in cycles from VALID seen.
  int cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r;
  logic [1:0] cfg_resp;
  logic [31:0] mem [4];
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic s_aw_got, s_w_got, s_r_pend;
  logic [3:0] s_awaddr, s_araddr;
  logic [31:0] s_wdata;

  assign AWREADY = AWVALID && (aw_cnt >= cfg_aw);
  assign WREADY  = WVALID && (w_cnt >= cfg_w);
  assign BVALID  = s_aw_got && s_w_got && (b_cnt >= cfg_b);
  assign BRESP   = BVALID ? cfg_resp : 2'b00;
  assign ARREADY = ARVALID && (ar_cnt >= cfg_ar);
  assign RVALID  = s_r_pend && (r_cnt >= cfg_r);
  assign RDATA   = RVALID ? mem[s_araddr[3:2]] : 32'h0;
  assign RRESP   = RVALID ? cfg_resp : 2'b00;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < 4; i++) mem[i] <= 32'hA0A0_0000 + 32'(i);
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      s_aw_got <= 1'b0; s_w_got <= 1'b0; s_r_pend <= 1'b0;
      s_awaddr <= '0; s_araddr <= '0; s_wdata <= '0;
    end else begin
      aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (WVALID && !WREADY) ? w_cnt + 1 : 0;
      ar_cnt <= (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
      if (AWVALID && AWREADY) begin
        s_aw_got <= 1'b1; s_awaddr <= AWADDR;
      end
      if (WVALID && WREADY) begin
        s_w_got <= 1'b1; s_wdata <= WDATA;
      end
      if (s_aw_got && s_w_got) begin
        if (BVALID && BREADY) begin
          mem[s_awaddr[3:2]] <= s_wdata;
          s_aw_got <= 1'b0; s_w_got <= 1'b0; b_cnt <= 0;
        end else begin
          b_cnt <= b_cnt + 1;
        end
      end
      if (ARVALID && ARREADY) begin
        s_r_pend <= 1'b1; s_araddr <= ARADDR; r_cnt <= 0;
      end else if (s_r_pend) begin
        if (RVALID && RREADY) begin
          s_r_pend <= 1'b0; r_cnt <= 0;
        end else begin
          r_cnt <= r_cnt + 1;
        end
      end
    end
  end

  int n_chk;
  int n_fail;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    int          idx;
    logic [3:0]  addr;
    logic [31:0] wdata;
    int          aw, w, b, ar, r;
    logic [1:0]  resp;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  task automatic set_cfg(input int aw, input int w, input int b,
                         input int ar, input int r, input logic [1:0] rs);
    cfg_aw = aw; cfg_w = w; cfg_b = b;
    cfg_ar = ar; cfg_r = r; cfg_resp = rs;
  endtask

  task automatic do_vec(input vec_t v);
    logic [1:0] oh;
    int lat, viol, busy_bad;
    logic aws, ws, ars, pa, pw, pb, pr, done;
    oh = 2'b01 << v.idx;
    set_cfg(v.aw, v.w, v.b, v.ar, v.r, v.resp);
    @(posedge ACLK); #1;
    req_valid = '0;
    req_valid[v.idx] = 1'b1;
    req_write[v.idx] = v.wr;
    req_addr[v.idx*4 +: 4] = v.addr;
    req_wdata[v.idx*32 +: 32] = v.wdata;
    @(negedge ACLK);
    chk("accept", 32'(req_ready), 32'(oh));
    @(posedge ACLK); #1;
    req_valid = '0;
    req_addr  = ~req_addr;
    req_wdata = ~req_wdata;
    req_write = ~req_write;
    lat = 0; viol = 0; busy_bad = 0;
    aws = 0; ws = 0; ars = 0; pa = 0; pw = 0; pb = 0; pr = 0; done = 0;
    for (int c = 1; c <= 100 && !done; c++) begin
      @(negedge ACLK);
      if (!busy) busy_bad++;
      if (v.wr) begin
        if (c == 1 && !(AWVALID && WVALID)) viol++;
        if (AWVALID && (aws || AWADDR != v.addr)) viol++;
        if (WVALID && (ws || WDATA != v.wdata)) viol++;
        if (pa && !AWVALID) viol++;
        if (pw && !WVALID) viol++;
        if (pb && !BREADY) viol++;
        if (BREADY && !(aws && ws)) viol++;
        if (ARVALID || RREADY) viol++;
        pa = AWVALID && !AWREADY;
        pw = WVALID && !WREADY;
        pb = BREADY && !BVALID;
        if (AWVALID && AWREADY) aws = 1;
        if (WVALID && WREADY) ws = 1;
      end else begin
        if (c == 1 && !ARVALID) viol++;
        if (ARVALID && (ars || ARADDR != v.addr)) viol++;
        if (pa && !ARVALID) viol++;
        if (pr && !RREADY) viol++;
        if (RREADY && !ars) viol++;
        if (AWVALID || WVALID || BREADY) viol++;
        pa = ARVALID && !ARREADY;
        pr = RREADY && !RVALID;
        if (ARVALID && ARREADY) ars = 1;
      end
      if (rsp_valid != 2'b00) begin
        done = 1;
        lat = c;
      end
    end
    chk("latency", 32'(lat), 32'(v.exp_lat));
    chk("rsp_valid", 32'(rsp_valid), 32'(oh));
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_resp", 32'(rsp_resp), 32'(v.resp));
    chk("busy_held", 32'(busy_bad), 32'd0);
    chk("protocol", 32'(viol), 32'd0);
    @(negedge ACLK);
    chk("rsp_pulse_end", {29'd0, rsp_valid, busy}, 32'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, {22'd0, req_ready, rsp_valid, busy, AWVALID,
        WVALID, BREADY, ARVALID, RREADY}, 32'd0);
    chk({nm, "_rdata"}, rsp_rdata, 32'd0);
    chk({nm, "_addr"}, {22'd0, rsp_resp, AWADDR, ARADDR}, 32'd0);
    chk({nm, "_wdata"}, WDATA, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_g;
    int c;
    n_chk = 0;
    n_fail = 0;
    //            wr  idx addr  wdata          aw w b ar r resp rdata        lat
    vecs[0] = '{1'b1, 0, 4'h4, 32'hDEADBEEF, 1, 1, 0, 1, 0, 2'b00, 32'h00000000, 4};
    vecs[1] = '{1'b0, 0, 4'h4, 32'h0,        1, 1, 0, 1, 0, 2'b00, 32'hDEADBEEF, 4};
    vecs[2] = '{1'b1, 1, 4'hC, 32'h12345678, 3, 0, 0, 1, 0, 2'b00, 32'hDEADBEEF, 6};
    vecs[3] = '{1'b0, 1, 4'hC, 32'h0,        1, 1, 0, 1, 4, 2'b00, 32'h12345678, 8};
    vecs[4] = '{1'b1, 0, 4'h8, 32'hCAFEF00D, 1, 1, 5, 1, 0, 2'b00, 32'h12345678, 9};
    vecs[5] = '{1'b0, 1, 4'h8, 32'h0,        1, 1, 0, 2, 0, 2'b10, 32'hCAFEF00D, 5};
    vecs[6] = '{1'b1, 0, 4'h0, 32'h0BADF00D, 0, 2, 1, 1, 0, 2'b01, 32'hCAFEF00D, 6};
    vecs[7] = '{1'b0, 1, 4'h0, 32'h0,        1, 1, 0, 0, 0, 2'b00, 32'h0BADF00D, 3};

    set_cfg(1, 1, 0, 1, 0, 2'b00);
    ARESET    = 1'b1;
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr  = 8'h44;
    req_wdata = {32'h1, 32'h2};
    repeat (2) @(negedge ACLK);
    chk_all_zero("reset");
    req_valid = 2'b00;
    ARESET = 1'b0;

    for (int i = 0; i < 8; i++) do_vec(vecs[i]);

    // Reset while waiting in WR_RESP for a late BVALID.
    set_cfg(1, 1, 10, 1, 0, 2'b00);
    @(posedge ACLK); #1;
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr  = 8'h04;
    req_wdata = {32'h0, 32'h55};
    c = 0;
    while (!BREADY && c < 20) begin
      @(negedge ACLK);
      c++;
    end
    chk("bready_pre_reset", 32'(BREADY), 32'd1);
    #1;
    ARESET    = 1'b1;
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr  = 8'h80;
    #1;
    chk_all_zero("async_reset");
    set_cfg(1, 1, 0, 1, 0, 2'b00);
    repeat (2) begin
      @(negedge ACLK);
      chk("in_reset", {29'd0, rsp_valid, busy}, 32'd0);
    end
    ARESET = 1'b0;
    #1;

    // Both requesters hold reads from reset: grants must alternate.
    for (int g = 0; g < 4; g++) begin
      exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
      c = 0;
      while (req_ready == 2'b00 && c < 20) begin
        @(negedge ACLK);
        c++;
      end
      chk("rr_grant", 32'(req_ready), 32'(exp_g));
      c = 0;
      while (rsp_valid == 2'b00 && c < 20) begin
        @(negedge ACLK);
        c++;
      end
      chk("rr_rsp_valid", 32'(rsp_valid), 32'(exp_g));
      chk("rr_rdata", rsp_rdata,
          exp_g[1] ? 32'hA0A0_0002 : 32'hA0A0_0000);
    end
    req_valid = 2'b00;
    repeat (3) @(negedge ACLK);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
